// File: rtl/comparator32_sar_search_if.sv
`default_nettype none
// ============================================================================
//  Module   : comparator32_sar_search_if
//  Purpose  : Start/status and comparator-flag bundle for the SAR search engine
//  Revision : 1.0  initial release
// ============================================================================
interface comparator32_sar_search_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             gt_i;
   logic             lt_i;
   logic             eq_i;
   logic [WIDTH-1:0] probe_o;
   logic             busy_o;
   logic             done_o;
   logic             found_o;
   logic             error_o;
   logic [WIDTH-1:0] result_o;

   // Engine side
   modport slave (
      input  start_i, gt_i, lt_i, eq_i,
      output probe_o, busy_o, done_o, found_o, error_o, result_o
   );

   // Controller / comparator side
   modport master (
      output start_i, gt_i, lt_i, eq_i,
      input  probe_o, busy_o, done_o, found_o, error_o, result_o
   );
endinterface
`default_nettype wire

// File: rtl/comparator32_sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : comparator32_sar_search
//  Purpose  : Successive-approximation recovery of a value seen only via a comparator
//  Revision : 1.0  initial release
// ============================================================================
module comparator32_sar_search #(
   parameter int WIDTH = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   comparator32_sar_search_if.slave      bus
);

   localparam logic [1:0]       c_st_idle   = 2'd0;
   localparam logic [1:0]       c_st_probe  = 2'd1;
   localparam logic [1:0]       c_st_verify = 2'd2;
   localparam logic [1:0]       c_st_done   = 2'd3;
   localparam logic [WIDTH-1:0] c_msb       = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_probe;
   logic [WIDTH-1:0] r_mask;      // one-hot marker of bit k under decision
   logic [WIDTH-1:0] r_result;
   logic             r_found;
   logic             r_error;

   logic             w_onehot;
   logic [WIDTH-1:0] w_next_probe;

   always_comb begin
      w_onehot = 1'b0;
      case ({bus.gt_i, bus.lt_i, bus.eq_i})
         3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
         default:                w_onehot = 1'b0;
      endcase
   end

   // Clear bit k when probe overshoots, then trial-set bit k-1 (empty when k==0).
   assign w_next_probe = (bus.gt_i ? (r_probe & ~r_mask) : r_probe) | (r_mask >> 1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= c_st_idle;
         r_probe  <= '0;
         r_mask   <= '0;
         r_result <= '0;
         r_found  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.start_i) begin
                  r_probe <= c_msb;
                  r_mask  <= c_msb;
                  r_found <= 1'b0;
                  r_error <= 1'b0;
                  r_state <= c_st_probe;
               end
            end
            c_st_probe: begin
               if (!w_onehot) begin
                  r_error <= 1'b1;
                  r_found <= 1'b0;
                  r_state <= c_st_done;
               end else if (bus.eq_i) begin
                  r_result <= r_probe;
                  r_found  <= 1'b1;
                  r_state  <= c_st_done;
               end else begin
                  r_probe <= w_next_probe;
                  r_mask  <= r_mask >> 1;
                  if (r_mask[0]) begin
                     r_state <= c_st_verify;
                  end
               end
            end
            c_st_verify: begin
               r_result <= r_probe;
               r_found  <= bus.eq_i & w_onehot;
               if (!w_onehot) begin
                  r_error <= 1'b1;
               end
               r_state <= c_st_done;
            end
            c_st_done: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign bus.probe_o  = r_probe;
   assign bus.result_o = r_result;
   assign bus.found_o  = r_found;
   assign bus.error_o  = r_error;
   assign bus.busy_o   = (r_state == c_st_probe) || (r_state == c_st_verify);
   assign bus.done_o   = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_comparator32_sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comparator32_sar_search
//  Purpose  : Directed self-checking bench; comparator modelled with a target register
//  Revision : 1.0  initial release
// ============================================================================
module tb_comparator32_sar_search;

   logic        clk_i;
   logic        rst_n_i;
   logic [31:0] target;
   logic        force_bad;
   int          n_checks;
   int          n_errors;
   int          cyc;

   comparator32_sar_search_if #(.WIDTH(32)) cmp_if ();

   comparator32_sar_search #(.WIDTH(32)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (cmp_if.slave)
   );

   // Combinational comparator32 model; force_bad drives an illegal flag pattern
   assign cmp_if.gt_i = force_bad ? 1'b1 : (cmp_if.probe_o > target);
   assign cmp_if.lt_i = force_bad ? 1'b1 : (cmp_if.probe_o < target);
   assign cmp_if.eq_i = force_bad ? 1'b0 : (cmp_if.probe_o == target);

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_probe"},  cmp_if.probe_o,  32'h0);
      chk({tag, "_result"}, cmp_if.result_o, 32'h0);
      chk({tag, "_busy"},   {31'b0, cmp_if.busy_o},  32'h0);
      chk({tag, "_done"},   {31'b0, cmp_if.done_o},  32'h0);
      chk({tag, "_found"},  {31'b0, cmp_if.found_o}, 32'h0);
      chk({tag, "_error"},  {31'b0, cmp_if.error_o}, 32'h0);
   endtask

   // Called just after edge 0; returns the cycle in which done_o is seen (0 = timeout)
   task automatic wait_done(input int force_cyc, output int seen);
      int  c;
      bit  got;
      c    = 1;
      got  = 1'b0;
      seen = 0;
      while (c <= 40 && !got) begin
         @(negedge clk_i);
         force_bad = (c == force_cyc);
         if (cmp_if.done_o) begin
            got  = 1'b1;
            seen = c;
         end else begin
            c++;
         end
      end
      force_bad = 1'b0;
   endtask

   task automatic launch(input logic [31:0] tgt, input string tag);
      target = tgt;
      @(negedge clk_i);
      cmp_if.start_i = 1'b1;
      @(posedge clk_i);
      #1 cmp_if.start_i = 1'b0;
      chk({tag, "_busy_c1"},  {31'b0, cmp_if.busy_o},  32'h1);
      chk({tag, "_probe_c1"}, cmp_if.probe_o,          32'h8000_0000);
      chk({tag, "_error_c1"}, {31'b0, cmp_if.error_o}, 32'h0);
      chk({tag, "_found_c1"}, {31'b0, cmp_if.found_o}, 32'h0);
   endtask

   task automatic search(input logic [31:0] tgt, input int exp_cyc, input string tag);
      int seen;
      launch(tgt, tag);
      wait_done(0, seen);
      chk({tag, "_done_cycle"}, seen, exp_cyc);
      chk({tag, "_result"}, cmp_if.result_o, tgt);
      chk({tag, "_found"},  {31'b0, cmp_if.found_o}, 32'h1);
      chk({tag, "_error"},  {31'b0, cmp_if.error_o}, 32'h0);
      chk({tag, "_busy_in_done"}, {31'b0, cmp_if.busy_o}, 32'h0);
      @(negedge clk_i);
      chk({tag, "_done_pulse"}, {31'b0, cmp_if.done_o}, 32'h0);
      chk({tag, "_result_hold"}, cmp_if.result_o, tgt);
   endtask

   initial begin
      int seen;
      n_checks       = 0;
      n_errors       = 0;
      force_bad      = 1'b0;
      target         = 32'h0;
      cmp_if.start_i = 1'b0;
      rst_n_i        = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk_all_zero("reset");
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("idle_busy", {31'b0, cmp_if.busy_o}, 32'h0);

      // 1: hit on the very first probe
      search(32'h8000_0000, 2, "t1_msb");
      // 2: every probe overshoots, resolved by VERIFY
      search(32'h0000_0000, 34, "t2_zero");
      // 3: equality on the last probed bit
      search(32'hFFFF_FFFF, 33, "t3_ones");
      search(32'h0000_0001, 33, "t3_one");

      // 4: start held high through two back-to-back searches
      target = 32'h7777_7777;
      @(negedge clk_i);
      cmp_if.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      wait_done(0, seen);
      chk("t4a_done_cycle", seen, 33);
      chk("t4a_result", cmp_if.result_o, 32'h7777_7777);
      chk("t4a_found", {31'b0, cmp_if.found_o}, 32'h1);
      target = 32'h5555_5555;
      @(negedge clk_i);
      chk("t4_idle_gap_busy", {31'b0, cmp_if.busy_o}, 32'h0);
      chk("t4_idle_gap_done", {31'b0, cmp_if.done_o}, 32'h0);
      @(posedge clk_i);
      #1;
      chk("t4b_busy_c1", {31'b0, cmp_if.busy_o}, 32'h1);
      chk("t4b_probe_c1", cmp_if.probe_o, 32'h8000_0000);
      wait_done(0, seen);
      cmp_if.start_i = 1'b0;
      chk("t4b_done_cycle", seen, 33);
      chk("t4b_result", cmp_if.result_o, 32'h5555_5555);
      chk("t4b_found", {31'b0, cmp_if.found_o}, 32'h1);
      @(negedge clk_i);
      @(negedge clk_i);

      // 5: illegal flags in cycle 5
      launch(32'h1234_5678, "t5_err");
      wait_done(5, seen);
      chk("t5_done_cycle", seen, 6);
      chk("t5_error", {31'b0, cmp_if.error_o}, 32'h1);
      chk("t5_found", {31'b0, cmp_if.found_o}, 32'h0);
      @(negedge clk_i);
      chk("t5_error_sticky", {31'b0, cmp_if.error_o}, 32'h1);
      search(32'h1234_5678, 30, "t5_recover");

      // 6: asynchronous reset in cycle 10 of a search
      launch(32'hA5A5_0F00, "t6_abort");
      repeat (9) @(negedge clk_i);
      chk("t6_busy_before_rst", {31'b0, cmp_if.busy_o}, 32'h1);
      rst_n_i = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      @(negedge clk_i);
      rst_n_i = 1'b1;
      // lowest set bit 8 -> eq at k=8 -> done in cycle 25
      search(32'hA5A5_0F00, 25, "t6_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
